arm_dp_core: RTL and testbench

ARM_DP_CORE -- requirements
Module: arm_dp_core

---
 rtl/arm_dp_core.sv | 244 ++++++++++++++++++++++++
 tb/tb_arm_dp_core.sv | 303 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/arm_dp_core.sv
// arm_dp_core: multi-cycle ARM data-processing subset core.
// Fetches one 32-bit word per instruction, decodes the ARM data-processing
// class (immediate or plain-register operand 2) and writes back two cycles
// after the fetch is accepted. Anything outside that class stops the core.
//
// Ports:
//   clk         single clock, rising-edge
//   n_reset     asynchronous active-low reset
//   imem_req    fetch request, held high in FETCH until imem_valid
//   imem_addr   word address of the fetch (pc[ADDR_W+1:2])
//   imem_valid  instruction word present on imem_rdata
//   imem_rdata  instruction word
//   halted      high while the core is stopped on an unsupported instruction
//   flags       CPSR {N,Z,C,V}
//   dbg_sel     debug register select
//   dbg_data    R[dbg_sel], pc when dbg_sel = 15
module arm_dp_core #(
    parameter int          ADDR_W   = 16,
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input  logic              clk,
    input  logic              n_reset,
    output logic              imem_req,
    output logic [ADDR_W-1:0] imem_addr,
    input  logic              imem_valid,
    input  logic [31:0]       imem_rdata,
    output logic              halted,
    output logic [3:0]        flags,
    input  logic [3:0]        dbg_sel,
    output logic [31:0]       dbg_data
);

    typedef enum logic [2:0] {
        S_IDLE    = 3'd0,
        S_FETCH   = 3'd1,
        S_DECODE  = 3'd2,
        S_EXECUTE = 3'd3,
        S_HALT    = 3'd4
    } state_t;

    state_t      r_state;
    state_t      w_next_state;
    logic [31:0] r_pc;
    logic [31:0] r_ir;
    logic [3:0]  r_flags;
    logic        r_imem_req;
    logic        r_halted;
    logic        r_c_in;
    logic [31:0] r_gpr [0:14];

    logic [31:0] w_rn;
    logic [31:0] w_rm;
    logic [31:0] w_op2;
    logic [31:0] w_x;
    logic [31:0] w_y;
    logic        w_cin;
    logic        w_arith;
    logic [31:0] w_logic;
    logic [32:0] w_sum;
    logic [31:0] w_res;
    logic        w_c_out;
    logic        w_v_out;
    logic        w_wr;
    logic        w_cond;

    // ARM condition codes evaluated on {N,Z,C,V}; 0xF never passes.
    function automatic logic cond_pass(input logic [3:0] c, input logic [3:0] f);
        logic n, z, cf, v;
        n  = f[3];
        z  = f[2];
        cf = f[1];
        v  = f[0];
        case (c)
            4'h0:    return z;
            4'h1:    return !z;
            4'h2:    return cf;
            4'h3:    return !cf;
            4'h4:    return n;
            4'h5:    return !n;
            4'h6:    return v;
            4'h7:    return !v;
            4'h8:    return cf && !z;
            4'h9:    return !cf || z;
            4'hA:    return n == v;
            4'hB:    return n != v;
            4'hC:    return !z && (n == v);
            4'hD:    return z || (n != v);
            4'hE:    return 1'b1;
            default: return 1'b0;
        endcase
    endfunction

    // Non data-processing, shifted-register operands and the MRS/MSR slot
    // (compare opcodes with S clear) are not handled by this core.
    function automatic logic is_unsupported(input logic [31:0] ir);
        return (ir[27:26] != 2'b00) ||
               (!ir[25] && (ir[11:4] != 8'h00)) ||
               ((ir[24:23] == 2'b10) && !ir[20]);
    endfunction

    // 8-bit immediate rotated right by twice the 4-bit rotate field.
    function automatic logic [31:0] ror_imm(input logic [7:0] imm, input logic [3:0] rot);
        logic [31:0] v;
        logic [5:0]  sh;
        v  = {24'h00_0000, imm};
        sh = {1'b0, rot, 1'b0};
        return (v >> sh) | (v << (6'd32 - sh));
    endfunction

    // Register reads; R15 as an operand is the current fetch address + 8,
    // which is pc + 4 because pc already advanced when the word was accepted.
    always_comb begin
        if (r_ir[19:16] == 4'd15) begin
            w_rn = r_pc + 32'd4;
        end else begin
            w_rn = r_gpr[r_ir[19:16]];
        end
        if (r_ir[3:0] == 4'd15) begin
            w_rm = r_pc + 32'd4;
        end else begin
            w_rm = r_gpr[r_ir[3:0]];
        end
        if (dbg_sel == 4'd15) begin
            dbg_data = r_pc;
        end else begin
            dbg_data = r_gpr[dbg_sel];
        end
    end

    assign w_op2  = r_ir[25] ? ror_imm(r_ir[7:0], r_ir[11:8]) : w_rm;
    assign w_cond = cond_pass(r_ir[31:28], r_flags);
    assign w_wr   = (r_ir[24:23] != 2'b10);

    // ALU: every arithmetic op is mapped onto x + y + cin, subtraction by
    // inverting one addend, so carry and overflow come from one adder.
    always_comb begin
        w_x     = w_rn;
        w_y     = w_op2;
        w_cin   = 1'b0;
        w_arith = 1'b0;
        w_logic = 32'h0000_0000;
        case (r_ir[24:21])
            4'h0, 4'h8: w_logic = w_rn & w_op2;
            4'h1, 4'h9: w_logic = w_rn ^ w_op2;
            4'hC:       w_logic = w_rn | w_op2;
            4'hD:       w_logic = w_op2;
            4'hE:       w_logic = w_rn & ~w_op2;
            4'hF:       w_logic = ~w_op2;
            4'h2, 4'hA: begin w_y = ~w_op2; w_cin = 1'b1;   w_arith = 1'b1; end
            4'h3:       begin w_x = ~w_rn;  w_cin = 1'b1;   w_arith = 1'b1; end
            4'h4, 4'hB: begin                               w_arith = 1'b1; end
            4'h5:       begin w_cin = r_c_in;               w_arith = 1'b1; end
            4'h6:       begin w_y = ~w_op2; w_cin = r_c_in; w_arith = 1'b1; end
            4'h7:       begin w_x = ~w_rn;  w_cin = r_c_in; w_arith = 1'b1; end
            default:    w_logic = 32'h0000_0000;
        endcase
        w_sum = {1'b0, w_x} + {1'b0, w_y} + {32'h0000_0000, w_cin};
        if (w_arith) begin
            w_res   = w_sum[31:0];
            w_c_out = w_sum[32];
            w_v_out = (w_x[31] == w_y[31]) && (w_sum[31] != w_x[31]);
        end else begin
            w_res   = w_logic;
            w_c_out = r_flags[1];
            w_v_out = r_flags[0];
        end
    end

    // Next-state logic.
    always_comb begin
        w_next_state = r_state;
        case (r_state)
            S_IDLE:    w_next_state = S_FETCH;
            S_FETCH:   w_next_state = imem_valid ? S_DECODE : S_FETCH;
            S_DECODE: begin
                if (is_unsupported(r_ir)) begin
                    w_next_state = S_HALT;
                end else if (w_cond) begin
                    w_next_state = S_EXECUTE;
                end else begin
                    w_next_state = S_FETCH;
                end
            end
            S_EXECUTE: w_next_state = S_FETCH;
            S_HALT:    w_next_state = S_HALT;
            default:   w_next_state = S_IDLE;
        endcase
    end

    // State register and registered request/halt outputs.
    always_ff @(posedge clk or negedge n_reset) begin
        if (!n_reset) begin
            r_state    <= S_IDLE;
            r_imem_req <= 1'b0;
            r_halted   <= 1'b0;
        end else begin
            r_state    <= w_next_state;
            r_imem_req <= (w_next_state == S_FETCH);
            r_halted   <= (w_next_state == S_HALT);
        end
    end

    // Architectural state: fetch latch, carry sample, writeback.
    always_ff @(posedge clk or negedge n_reset) begin
        if (!n_reset) begin
            r_pc    <= RESET_PC;
            r_ir    <= 32'h0000_0000;
            r_flags <= 4'b0000;
            r_c_in  <= 1'b0;
            for (int i = 0; i < 15; i++) begin
                r_gpr[i] <= 32'h0000_0000;
            end
        end else begin
            case (r_state)
                S_FETCH: begin
                    if (imem_valid) begin
                        r_ir <= imem_rdata;
                        r_pc <= r_pc + 32'd4;
                    end
                end
                S_DECODE: r_c_in <= r_flags[1];
                S_EXECUTE: begin
                    if (w_wr) begin
                        if (r_ir[15:12] == 4'd15) begin
                            r_pc <= w_res & ~32'h0000_0003;
                        end else begin
                            r_gpr[r_ir[15:12]] <= w_res;
                        end
                    end
                    if (r_ir[20]) begin
                        r_flags <= {w_res[31], (w_res == 32'h0000_0000), w_c_out, w_v_out};
                    end
                end
                default: r_c_in <= r_c_in;
            endcase
        end
    end

    assign imem_req  = r_imem_req;
    assign imem_addr = r_pc[ADDR_W+1:2];
    assign halted    = r_halted;
    assign flags     = r_flags;

endmodule

// File: tb/tb_arm_dp_core.sv
`timescale 1ns/1ps
module tb_arm_dp_core;
    localparam int          ADDR_W = 16;
    localparam logic [31:0] RPC    = 32'h0000_0100;
    localparam longint      SMAX   = 64'sh0000_0000_7FFF_FFFF;
    localparam longint      SMIN   = -64'sh0000_0000_8000_0000;
    localparam longint      UMAX   = 64'sh0000_0000_FFFF_FFFF;

    logic              clk;
    logic              n_reset;
    logic              imem_req;
    logic [ADDR_W-1:0] imem_addr;
    logic              imem_valid;
    logic [31:0]       imem_rdata;
    logic              halted;
    logic [3:0]        flags;
    logic [3:0]        dbg_sel;
    logic [31:0]       dbg_data;

    int n_pass;
    int n_fail;
    int n_total;

    // Architectural reference state.
    logic [31:0] m_reg [0:14];
    logic [31:0] m_pc;
    logic [3:0]  m_flags;
    logic        m_halted;

    arm_dp_core #(.ADDR_W(ADDR_W), .RESET_PC(RPC)) dut (
        .clk(clk), .n_reset(n_reset), .imem_req(imem_req), .imem_addr(imem_addr),
        .imem_valid(imem_valid), .imem_rdata(imem_rdata), .halted(halted),
        .flags(flags), .dbg_sel(dbg_sel), .dbg_data(dbg_data)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_total++;
        assert (obs === exp) n_pass++;
        else begin
            n_fail++;
            $error("FAIL %s observed=%08h expected=%08h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [31:0] m_read(input logic [3:0] idx, input logic [31:0] fa);
        if (idx == 4'd15) return fa + 32'd8;
        return m_reg[idx];
    endfunction

    function automatic bit m_cond(input logic [3:0] c, input logic [3:0] f);
        bit n, z, cf, v;
        n = f[3]; z = f[2]; cf = f[1]; v = f[0];
        case (c)
            4'h0: return z;          4'h1: return !z;
            4'h2: return cf;         4'h3: return !cf;
            4'h4: return n;          4'h5: return !n;
            4'h6: return v;          4'h7: return !v;
            4'h8: return cf && !z;   4'h9: return !cf || z;
            4'hA: return n == v;     4'hB: return n != v;
            4'hC: return !z && (n == v);
            4'hD: return z || (n != v);
            4'hE: return 1'b1;
            default: return 1'b0;
        endcase
    endfunction

    task automatic model_reset();
        for (int i = 0; i < 15; i++) m_reg[i] = 32'h0;
        m_pc = RPC;
        m_flags = 4'b0000;
        m_halted = 1'b0;
    endtask

    // Executes one instruction on the reference state using integer arithmetic.
    // kind: 0 executed, 1 condition failed, 2 unsupported (halt).
    task automatic model_exec(input logic [31:0] ins, output int kind);
        logic [31:0] fa, a, b, r;
        longint ua, ub, sa, sb, full, c, nc;
        bit cf, vf, arith;
        fa = m_pc;
        m_pc = m_pc + 32'd4;
        if (ins[27:26] != 2'b00 || (!ins[25] && ins[11:4] != 8'h00) ||
            (ins[24:23] == 2'b10 && !ins[20])) begin
            kind = 2;
            return;
        end
        if (!m_cond(ins[31:28], m_flags)) begin
            kind = 1;
            return;
        end
        kind = 0;
        if (ins[25]) begin
            b = {24'h0, ins[7:0]};
            for (int k = 0; k < 2 * ins[11:8]; k++) b = {b[0], b[31:1]};
        end else begin
            b = m_read(ins[3:0], fa);
        end
        a = m_read(ins[19:16], fa);
        ua = a; ub = b; sa = $signed(a); sb = $signed(b);
        c = m_flags[1] ? 64'sd1 : 64'sd0;
        nc = 64'sd1 - c;
        arith = 1'b1; cf = m_flags[1]; vf = m_flags[0]; full = 0; r = 32'h0;
        case (ins[24:21])
            4'h0, 4'h8: begin r = a & b;  arith = 1'b0; end
            4'h1, 4'h9: begin r = a ^ b;  arith = 1'b0; end
            4'hC:       begin r = a | b;  arith = 1'b0; end
            4'hD:       begin r = b;      arith = 1'b0; end
            4'hE:       begin r = a & ~b; arith = 1'b0; end
            4'hF:       begin r = ~b;     arith = 1'b0; end
            4'h4, 4'hB: begin cf = (ua + ub) > UMAX;     full = sa + sb;      end
            4'h5:       begin cf = (ua + ub + c) > UMAX; full = sa + sb + c;  end
            4'h2, 4'hA: begin cf = ua >= ub;             full = sa - sb;      end
            4'h6:       begin cf = ua >= ub + nc;        full = sa - sb - nc; end
            4'h3:       begin cf = ub >= ua;             full = sb - sa;      end
            default:    begin cf = ub >= ua + nc;        full = sb - sa - nc; end
        endcase
        if (arith) begin
            r = full[31:0];
            vf = (full > SMAX) || (full < SMIN);
        end
        if (ins[24:23] != 2'b10) begin
            if (ins[15:12] == 4'd15) m_pc = r & ~32'h3;
            else m_reg[ins[15:12]] = r;
        end
        if (ins[20]) m_flags = {r[31], r == 32'h0, cf, vf};
    endtask

    task automatic compare_state(input string tag);
        check({tag, " flags"}, {28'h0, flags}, {28'h0, m_flags});
        check({tag, " halted"}, {31'h0, halted}, {31'h0, m_halted});
        check({tag, " addr"}, {16'h0, imem_addr}, {16'h0, m_pc[17:2]});
        for (int i = 0; i < 15; i++) begin
            dbg_sel = 4'(i);
            #1;
            check($sformatf("%s r%0d", tag, i), dbg_data, m_reg[i]);
        end
        dbg_sel = 4'd15;
        #1;
        check({tag, " pc"}, dbg_data, m_pc);
        step();
    endtask

    task automatic wait_req(input string tag);
        int n;
        n = 0;
        while (!imem_req && n < 20) begin
            step();
            n++;
        end
        check({tag, " req_wait"}, {31'h0, imem_req}, 32'h1);
    endtask

    task automatic run_instr(input logic [31:0] ins, input int waitc, input string tag);
        int kind, lat;
        logic [ADDR_W-1:0] a0;
        wait_req(tag);
        a0 = imem_addr;
        for (int w = 0; w < waitc; w++) begin
            step();
            check({tag, " stall_req"}, {31'h0, imem_req}, 32'h1);
            check({tag, " stall_addr"}, {16'h0, imem_addr}, {16'h0, a0});
        end
        imem_valid = 1'b1;
        imem_rdata = ins;
        @(posedge clk);
        #1;
        imem_valid = 1'b0;
        imem_rdata = $urandom();
        model_exec(ins, kind);
        lat = 0;
        do begin
            step();
            lat++;
        end while (!imem_req && !halted && lat < 10);
        check({tag, " latency"}, 32'(lat), (kind == 0) ? 32'd2 : 32'd1);
        if (kind == 2) m_halted = 1'b1;
        compare_state(tag);
    endtask

    task automatic do_reset(input string tag);
        n_reset = 1'b0;
        imem_valid = 1'b0;
        step();
        step();
        model_reset();
        check({tag, " rst_req"}, {31'h0, imem_req}, 32'h0);
        check({tag, " rst_halted"}, {31'h0, halted}, 32'h0);
        check({tag, " rst_flags"}, {28'h0, flags}, 32'h0);
        dbg_sel = 4'd15;
        #1;
        check({tag, " rst_pc"}, dbg_data, RPC);
        dbg_sel = 4'd9;
        #1;
        check({tag, " rst_r9"}, dbg_data, 32'h0);
        step();
        n_reset = 1'b1;
        #1;
        check({tag, " req_before_edge1"}, {31'h0, imem_req}, 32'h0);
        // Request is raised by the first edge, so it is presented at the second.
        step();
        check({tag, " req_after_edge1"}, {31'h0, imem_req}, 32'h1);
    endtask

    initial begin
        logic [31:0] ins;
        logic [3:0]  op, rd;
        n_pass = 0; n_fail = 0; n_total = 0;
        n_reset = 1'b0; imem_valid = 1'b0; imem_rdata = 32'h0; dbg_sel = 4'd0;
        do_reset("por");

        // Reset in FETCH while a word is being offered.
        imem_valid = 1'b1;
        imem_rdata = 32'hE3A014FF;
        #2;
        n_reset = 1'b0;
        #1;
        check("midfetch req", {31'h0, imem_req}, 32'h0);
        dbg_sel = 4'd15;
        #1;
        check("midfetch pc", dbg_data, RPC);
        step();
        dbg_sel = 4'd1;
        #1;
        check("midfetch r1", dbg_data, 32'h0);
        do_reset("rst2");

        run_instr(32'hE3A014FF, 5, "mov_rot");
        dbg_sel = 4'd1; #1; check("mov_rot const", dbg_data, 32'hFF00_0000);
        run_instr(32'hE3B02000, 0, "movs0");
        check("movs0 const", {28'h0, flags}, 32'h4);
        run_instr(32'hE3E01000, 1, "mvn_r1");
        run_instr(32'hE2913001, 0, "adds_wrap");
        check("adds_wrap const", {28'h0, flags}, 32'h6);
        run_instr(32'h02814002, 0, "addeq");
        run_instr(32'h12814003, 2, "addne");
        dbg_sel = 4'd4; #1; check("addeq const", dbg_data, 32'h1);
        run_instr(32'hE3E05102, 0, "mvn_r5");
        run_instr(32'hE2956001, 0, "adds_ovf");
        check("adds_ovf const", {28'h0, flags}, 32'h9);
        run_instr(32'hE1550005, 0, "cmp_eq");
        check("cmp_eq const", {28'h0, flags}, 32'h6);
        run_instr(32'hE3A0FF10, 0, "mov_pc");
        check("mov_pc const", {16'h0, imem_addr}, 32'h10);

        for (int t = 0; t < 200; t++) begin
            op = 4'($urandom_range(0, 15));
            rd = ($urandom_range(0, 19) == 0) ? 4'd15 : 4'($urandom_range(0, 14));
            ins = 32'h0;
            ins[31:28] = ($urandom_range(0, 9) < 7) ? 4'hE : 4'($urandom_range(0, 15));
            ins[25]    = 1'($urandom_range(0, 1));
            ins[24:21] = op;
            ins[20]    = (op[3:2] == 2'b10) ? 1'b1 : 1'($urandom_range(0, 1));
            ins[19:16] = 4'($urandom_range(0, 15));
            ins[15:12] = rd;
            if (ins[25]) ins[11:0] = 12'($urandom_range(0, 4095));
            else ins[3:0] = 4'($urandom_range(0, 15));
            run_instr(ins, $urandom_range(0, 2), $sformatf("rnd%0d", t));
        end

        // Reset while a register write is in EXECUTE.
        do_reset("rst3");
        run_instr(32'hE3B08000, 0, "movs_r8");
        wait_req("rst_exec");
        imem_valid = 1'b1;
        imem_rdata = 32'hE3A07005;
        @(posedge clk);
        #1;
        imem_valid = 1'b0;
        step();
        #2;
        n_reset = 1'b0;
        #1;
        step();
        dbg_sel = 4'd7; #1; check("rst_exec r7", dbg_data, 32'h0);
        dbg_sel = 4'd15; #1; check("rst_exec pc", dbg_data, RPC);
        check("rst_exec flags", {28'h0, flags}, 32'h0);

        // Unsupported instruction halts and freezes the core.
        do_reset("rst4");
        run_instr(32'hE3A01033, 0, "pre_halt");
        run_instr(32'hEA000000, 0, "branch");
        imem_valid = 1'b1;
        imem_rdata = 32'hE3A01044;
        for (int h = 0; h < 5; h++) begin
            step();
            check("halt halted", {31'h0, halted}, 32'h1);
            check("halt req", {31'h0, imem_req}, 32'h0);
        end
        imem_valid = 1'b0;
        compare_state("halt_frozen");

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end
endmodule
